// File: rtl/l2cache_nway_pkg.sv
// Shared types for the N-way L2 cache: line type, controller state encoding
// and a width helper that keeps way-index vectors at least one bit wide.
package l2cache_nway_pkg;

    localparam int L2_LINE_W = 128;

    typedef logic [L2_LINE_W-1:0] lc3b_l2_line;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FILL
    } l2_state_t;

    // Width of a way index; a direct-mapped cache still carries a 1-bit index.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/l2cache_nway_if.sv
// Wishbone-style line bus used on both sides of the L2 cache.
// The master drives the request; the slave answers with data, ACK and RTY.
interface l2cache_nway_if #(
    parameter int ADR_W  = 12,
    parameter int DATA_W = 128
);
    logic                CYC;
    logic                STB;
    logic                WE;
    logic [DATA_W/8-1:0] SEL;
    logic [ADR_W-1:0]    ADR;
    logic [DATA_W-1:0]   DAT_M;
    logic [DATA_W-1:0]   DAT_S;
    logic                ACK;
    logic                RTY;

    modport master (output CYC, STB, WE, SEL, ADR, DAT_M, input DAT_S, ACK, RTY);
    modport slave  (input CYC, STB, WE, SEL, ADR, DAT_M, output DAT_S, ACK, RTY);
endinterface

// File: rtl/l2cache_nway_plru.sv
// Tree pseudo-LRU state for the L2 cache: WAYS-1 bits per set stored in
// heap order (root first). A bit of 0 points to the left subtree. The victim
// is found by following the pointers from the root; a hit flips every bit on
// its path to point away from the hit way.
module l2_plru
    import l2cache_nway_pkg::*;
#(
    parameter int WAYS = 4,
    parameter int SETS = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [$clog2(SETS)-1:0]       i_idx,
    input  logic                          i_upd,
    input  logic [clog2_min1(WAYS)-1:0]   i_hit_way,
    output logic [clog2_min1(WAYS)-1:0]   o_victim
);

    if (WAYS == 1) begin : g_direct
        logic w_unused_ports;
        assign w_unused_ports = ^{clk, rst, i_idx, i_upd, i_hit_way};
        assign o_victim       = '0;
    end else begin : g_tree
        localparam int LVL   = $clog2(WAYS);
        localparam int WAY_W = LVL;

        logic [WAYS-2:0] r_bits [SETS];

        // Walk from the root following each node's pointer down to a leaf.
        function automatic logic [WAY_W-1:0] f_victim(input logic [WAYS-2:0] bits);
            int              node;
            logic [WAYS-2:0] t;
            node = 1;
            for (int l = 0; l < LVL; l++) begin
                t    = bits >> (node - 1);
                node = 2 * node + (t[0] ? 1 : 0);
            end
            return WAY_W'(node - WAYS);
        endfunction

        // Point every node on the hit way's path at the opposite subtree.
        function automatic logic [WAYS-2:0] f_update(input logic [WAYS-2:0] bits,
                                                     input logic [WAY_W-1:0] way);
            int              node;
            logic [WAYS-2:0] b;
            logic [WAYS-2:0] m;
            logic [WAY_W-1:0] t;
            node = 1;
            b    = bits;
            for (int l = 0; l < LVL; l++) begin
                t = way >> (LVL - 1 - l);
                m = (WAYS-1)'(1) << (node - 1);
                b = t[0] ? (b & ~m) : (b | m);
                node = 2 * node + (t[0] ? 1 : 0);
            end
            return b;
        endfunction

        assign o_victim = f_victim(r_bits[i_idx]);

        // PLRU bits clear on reset and move away from the way of every hit.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int s = 0; s < SETS; s++) r_bits[s] <= '0;
            end else if (i_upd) begin
                r_bits[i_idx] <= f_update(r_bits[i_idx], i_hit_way);
            end
        end
    end

endmodule

// File: rtl/l2cache_nway.sv
// N-way set-associative, write-back, write-allocate L2 cache.
// Hits complete in the request cycle; misses optionally write back a dirty
// victim, then fill from memory, after which the held request hits.
// Optional feature macro: L2_PERF_CNT_EN adds hit_count / miss_count outputs.
module l2cache_nway
    import l2cache_nway_pkg::*;
#(
    parameter int WAYS   = 4,
    parameter int SETS   = 8,
    parameter int ADR_W  = 12,
    parameter int DATA_W = L2_LINE_W
) (
    input  logic          clk,
    input  logic          rst,
    l2cache_nway_if.slave  wb_cpu,
    l2cache_nway_if.master wb_mem
`ifdef L2_PERF_CNT_EN
    ,
    output logic [31:0]   hit_count,
    output logic [31:0]   miss_count
`endif
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADR_W - IDX_W;
    localparam int WAY_W = clog2_min1(WAYS);
    localparam int SEL_W = DATA_W / 8;

    logic [TAG_W-1:0]  r_tag   [WAYS][SETS];
    logic [DATA_W-1:0] r_data  [WAYS][SETS];
    logic [WAYS-1:0]   r_valid [SETS];
    logic [WAYS-1:0]   r_dirty [SETS];

    l2_state_t         r_state;
    logic [ADR_W-1:0]  r_madr;
    logic [WAY_W-1:0]  r_victim;

    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic [IDX_W-1:0]  w_midx;
    logic [TAG_W-1:0]  w_mtag;
    logic              w_req;
    logic              w_idle;
    logic              w_hit;
    logic [WAY_W-1:0]  w_hit_way;
    logic              w_ack;
    logic              w_miss;
    logic              w_wr_hit;
    logic              w_fill_done;
    logic              w_inv_found;
    logic [WAY_W-1:0]  w_inv_way;
    logic [WAY_W-1:0]  w_plru_way;
    logic [WAY_W-1:0]  w_victim;
    logic              w_victim_dirty;
    logic              w_unused_rty;

    assign w_idx  = wb_cpu.ADR[IDX_W-1:0];
    assign w_tag  = wb_cpu.ADR[ADR_W-1:IDX_W];
    assign w_midx = r_madr[IDX_W-1:0];
    assign w_mtag = r_madr[ADR_W-1:IDX_W];

    assign w_req       = wb_cpu.CYC & wb_cpu.STB;
    assign w_idle      = (r_state == IDLE);
    assign w_ack       = w_idle & w_req & w_hit;
    assign w_miss      = w_idle & w_req & ~w_hit;
    assign w_wr_hit    = w_ack & wb_cpu.WE;
    assign w_fill_done = (r_state == FILL) & wb_mem.ACK;

    // Tag compare across all ways of the addressed set.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w_idx][w] && (r_tag[w][w_idx] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
        end
    end

    // Victim choice: lowest-numbered invalid way, otherwise the PLRU way.
    always_comb begin
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_idx][w]) begin
                w_inv_found = 1'b1;
                w_inv_way   = WAY_W'(w);
            end
        end
    end

    assign w_victim       = w_inv_found ? w_inv_way : w_plru_way;
    assign w_victim_dirty = r_valid[w_idx][w_victim] & r_dirty[w_idx][w_victim];

    l2_plru #(
        .WAYS (WAYS),
        .SETS (SETS)
    ) u_plru (
        .clk       (clk),
        .rst       (rst),
        .i_idx     (w_idx),
        .i_upd     (w_ack),
        .i_hit_way (w_hit_way),
        .o_victim  (w_plru_way)
    );

    assign wb_cpu.ACK   = w_ack;
    assign wb_cpu.RTY   = w_req & ~w_ack;
    assign wb_cpu.DAT_S = r_data[w_hit_way][w_idx];

    // Memory side is decoded purely from state so reset drops it immediately.
    assign wb_mem.CYC   = (r_state != IDLE);
    assign wb_mem.STB   = (r_state != IDLE);
    assign wb_mem.WE    = (r_state == WRITEBACK);
    assign wb_mem.SEL   = '1;
    assign wb_mem.ADR   = (r_state == WRITEBACK) ? {r_tag[r_victim][w_midx], w_midx} : r_madr;
    assign wb_mem.DAT_M = r_data[r_victim][w_midx];
    assign w_unused_rty = wb_mem.RTY;

    // Controller: miss capture, writeback/fill sequencing, valid and dirty bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_madr   <= '0;
            r_victim <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_miss) begin
                        r_madr   <= wb_cpu.ADR;
                        r_victim <= w_victim;
                        r_state  <= w_victim_dirty ? WRITEBACK : FILL;
                    end
                    if (w_wr_hit && (wb_cpu.SEL != '0)) r_dirty[w_idx][w_hit_way] <= 1'b1;
                end
                WRITEBACK: begin
                    if (wb_mem.ACK) r_state <= FILL;
                end
                FILL: begin
                    if (wb_mem.ACK) begin
                        r_valid[w_midx][r_victim] <= 1'b1;
                        r_dirty[w_midx][r_victim] <= 1'b0;
                        r_state                   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Line storage: full-line install on fill, byte-masked update on write hit.
    always_ff @(posedge clk) begin
        if (w_fill_done) begin
            r_data[r_victim][w_midx] <= wb_mem.DAT_S;
            r_tag[r_victim][w_midx]  <= w_mtag;
        end else if (w_wr_hit) begin
            for (int b = 0; b < SEL_W; b++) begin
                if (wb_cpu.SEL[b]) r_data[w_hit_way][w_idx][b*8 +: 8] <= wb_cpu.DAT_M[b*8 +: 8];
            end
        end
    end

`ifdef L2_PERF_CNT_EN
    logic r_missed;

    // Count first-time hits and miss entries; the ACK that ends a miss is not a hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
            r_missed   <= 1'b0;
        end else begin
            if (w_miss) begin
                miss_count <= miss_count + 32'd1;
                r_missed   <= 1'b1;
            end else if (w_ack) begin
                if (!r_missed) hit_count <= hit_count + 32'd1;
                r_missed <= 1'b0;
            end else if (w_idle && !w_req) begin
                r_missed <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_l2cache_nway.sv
// Bench for l2cache_nway (WAYS=4, SETS=8): table of CPU requests with the
// memory traffic each one must cause, a scoreboard of expected memory cycles,
// and hand-written reset sequences.
module tb_l2cache_nway;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    l2cache_nway_if #(.ADR_W(12), .DATA_W(128)) cpu_if ();
    l2cache_nway_if #(.ADR_W(12), .DATA_W(128)) mem_if ();

`ifdef L2_PERF_CNT_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    l2cache_nway #(
        .WAYS   (4),
        .SETS   (8),
        .ADR_W  (12),
        .DATA_W (128)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_cpu     (cpu_if),
        .wb_mem     (mem_if)
`ifdef L2_PERF_CNT_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    typedef struct {
        logic         we;
        logic [11:0]  adr;
        logic [15:0]  sel;
        logic [127:0] dat;
        logic         chk_dat;
        logic [127:0] exp_dat;
        int           exp_cyc;
        logic         wb;
        logic [11:0]  wb_adr;
        logic [127:0] wb_dat;
        logic         fill;
        logic [11:0]  fill_adr;
    } vec_t;

    typedef struct {
        logic         we;
        logic [11:0]  adr;
        logic [127:0] dat;
    } mem_exp_t;

    mem_exp_t sb_q[$];
    vec_t     tv[20];
    int       total = 0;
    int       bad   = 0;

    // Backing-store contents: 0x010 is the all-A5 line, others encode their address.
    function automatic logic [127:0] f_mem(input logic [11:0] a);
        if (a == 12'h010) return {16{8'hA5}};
        return {8{4'hC, a}};
    endfunction

    function automatic logic [127:0] f_merge(input logic [127:0] old, input logic [127:0] nw,
                                             input logic [15:0] sel);
        logic [127:0] r;
        r = old;
        for (int b = 0; b < 16; b++) if (sel[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    function automatic vec_t mk(input logic we, input logic [11:0] adr, input logic [15:0] sel,
                                input logic [127:0] dat, input logic chk_dat,
                                input logic [127:0] exp_dat, input int exp_cyc,
                                input logic wb, input logic [11:0] wb_adr,
                                input logic [127:0] wb_dat, input logic fill,
                                input logic [11:0] fill_adr);
        vec_t v;
        v.we = we; v.adr = adr; v.sel = sel; v.dat = dat;
        v.chk_dat = chk_dat; v.exp_dat = exp_dat; v.exp_cyc = exp_cyc;
        v.wb = wb; v.wb_adr = wb_adr; v.wb_dat = wb_dat;
        v.fill = fill; v.fill_adr = fill_adr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one CPU request, serve memory cycles from the scoreboard, check the result.
    task automatic run_vec(input vec_t v, input int id);
        logic [127:0] rdat;
        int           cyc;
        bit           done;
        mem_exp_t     e;
        string        nm;
        nm = $sformatf("v%0d_%h", id, v.adr);
        if (v.wb)   sb_q.push_back('{we: 1'b1, adr: v.wb_adr, dat: v.wb_dat});
        if (v.fill) sb_q.push_back('{we: 1'b0, adr: v.fill_adr, dat: 128'h0});
        @(negedge clk);
        cpu_if.CYC = 1'b1; cpu_if.STB = 1'b1; cpu_if.WE = v.we;
        cpu_if.ADR = v.adr; cpu_if.SEL = v.sel; cpu_if.DAT_M = v.dat;
        cyc  = 0;
        done = 1'b0;
        rdat = '0;
        while (!done && cyc < 20) begin
            #1;
            if (cpu_if.ACK === 1'b1) begin
                done = 1'b1;
                rdat = cpu_if.DAT_S;
                chk({nm, "_rty_ack"}, 128'(cpu_if.RTY), 128'(0));
            end else begin
                chk({nm, "_rty_wait"}, 128'(cpu_if.RTY), 128'(1));
            end
            if (mem_if.CYC === 1'b1 && mem_if.STB === 1'b1) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL %s_mem: got cycle we=%b adr=%h expected no memory cycle",
                             nm, mem_if.WE, mem_if.ADR);
                end else begin
                    e = sb_q.pop_front();
                    chk({nm, "_mem_we"}, 128'(mem_if.WE), 128'(e.we));
                    chk({nm, "_mem_adr"}, 128'(mem_if.ADR), 128'(e.adr));
                    if (e.we) chk({nm, "_mem_wdat"}, mem_if.DAT_M, e.dat);
                end
                mem_if.DAT_S = f_mem(mem_if.ADR);
                mem_if.ACK   = 1'b1;
            end
            @(negedge clk);
            mem_if.ACK = 1'b0;
            if (!done) cyc++;
        end
        cpu_if.CYC = 1'b0; cpu_if.STB = 1'b0; cpu_if.WE = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no ACK in 20 cycles expected ACK", nm);
        end else begin
            chk({nm, "_ack_cyc"}, 128'(cyc), 128'(v.exp_cyc));
            if (v.chk_dat) chk({nm, "_rdat"}, rdat, v.exp_dat);
        end
        chk({nm, "_sb_left"}, 128'(sb_q.size()), 128'(0));
        sb_q.delete();
    endtask

    initial begin
        logic [127:0] m010, m030, dw;
        vec_t         v;

        m010 = {{15{8'hA5}}, 8'h3C};
        m030 = f_merge(f_mem(12'h030), {16{8'h77}}, 16'h8000);
        dw   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

        tv[0]  = mk(0, 12'h010, 16'h0000, '0, 1, {16{8'hA5}}, 2, 0, 12'h0, '0, 1, 12'h010);
        tv[1]  = mk(1, 12'h010, 16'h0001, {{15{8'hFF}}, 8'h3C}, 0, '0, 0, 0, 12'h0, '0, 0, 12'h0);
        tv[2]  = mk(0, 12'h010, 16'h0000, '0, 1, m010, 0, 0, 12'h0, '0, 0, 12'h0);
        tv[3]  = mk(0, 12'h018, 16'h0000, '0, 1, f_mem(12'h018), 2, 0, 12'h0, '0, 1, 12'h018);
        tv[4]  = mk(0, 12'h020, 16'h0000, '0, 1, f_mem(12'h020), 2, 0, 12'h0, '0, 1, 12'h020);
        tv[5]  = mk(0, 12'h028, 16'h0000, '0, 1, f_mem(12'h028), 2, 0, 12'h0, '0, 1, 12'h028);
        tv[6]  = mk(0, 12'h010, 16'h0000, '0, 1, m010, 0, 0, 12'h0, '0, 0, 12'h0);
        tv[7]  = mk(0, 12'h030, 16'h0000, '0, 1, f_mem(12'h030), 2, 0, 12'h0, '0, 1, 12'h030);
        tv[8]  = mk(0, 12'h028, 16'h0000, '0, 1, f_mem(12'h028), 0, 0, 12'h0, '0, 0, 12'h0);
        tv[9]  = mk(0, 12'h010, 16'h0000, '0, 1, m010, 0, 0, 12'h0, '0, 0, 12'h0);
        tv[10] = mk(1, 12'h030, 16'h8000, {16{8'h77}}, 0, '0, 0, 0, 12'h0, '0, 0, 12'h0);
        tv[11] = mk(0, 12'h018, 16'h0000, '0, 1, f_mem(12'h018), 0, 0, 12'h0, '0, 0, 12'h0);
        tv[12] = mk(0, 12'h028, 16'h0000, '0, 1, f_mem(12'h028), 0, 0, 12'h0, '0, 0, 12'h0);
        tv[13] = mk(0, 12'h038, 16'h0000, '0, 1, f_mem(12'h038), 3, 1, 12'h010, m010, 1, 12'h038);
        tv[14] = mk(0, 12'h020, 16'h0000, '0, 1, f_mem(12'h020), 3, 1, 12'h030, m030, 1, 12'h020);
        tv[15] = mk(1, 12'h028, 16'h0000, {16{8'hFF}}, 0, '0, 0, 0, 12'h0, '0, 0, 12'h0);
        tv[16] = mk(0, 12'h028, 16'h0000, '0, 1, f_mem(12'h028), 0, 0, 12'h0, '0, 0, 12'h0);
        tv[17] = mk(0, 12'h0A3, 16'h0000, '0, 1, f_mem(12'h0A3), 2, 0, 12'h0, '0, 1, 12'h0A3);
        tv[18] = mk(1, 12'h0A3, 16'hFFFF, dw, 0, '0, 0, 0, 12'h0, '0, 0, 12'h0);
        tv[19] = mk(0, 12'h0A3, 16'h0000, '0, 1, dw, 0, 0, 12'h0, '0, 0, 12'h0);

        // Reset with a request pending: retry asserted, no ACK, memory idle.
        rst = 1'b1;
        cpu_if.CYC = 1'b1; cpu_if.STB = 1'b1; cpu_if.WE = 1'b0;
        cpu_if.ADR = 12'h010; cpu_if.SEL = '0; cpu_if.DAT_M = '0;
        mem_if.ACK = 1'b0; mem_if.RTY = 1'b0; mem_if.DAT_S = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ack", 128'(cpu_if.ACK), 128'(0));
        chk("rst_rty", 128'(cpu_if.RTY), 128'(1));
        chk("rst_mem_cyc", 128'(mem_if.CYC), 128'(0));
        chk("rst_mem_stb", 128'(mem_if.STB), 128'(0));
        chk("rst_mem_we", 128'(mem_if.WE), 128'(0));
`ifdef L2_PERF_CNT_EN
        chk("rst_hit_cnt", 128'(hit_count), 128'(0));
        chk("rst_miss_cnt", 128'(miss_count), 128'(0));
`endif
        @(negedge clk);
        cpu_if.CYC = 1'b0; cpu_if.STB = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            v = tv[i];
            run_vec(v, i);
`ifdef L2_PERF_CNT_EN
            if (i == 2) begin
                chk("perf_hit_cnt", 128'(hit_count), 128'(2));
                chk("perf_miss_cnt", 128'(miss_count), 128'(1));
            end
`endif
        end

        // Reset in the middle of a fill: memory cycle drops at once, line not installed.
        @(negedge clk);
        cpu_if.CYC = 1'b1; cpu_if.STB = 1'b1; cpu_if.WE = 1'b0;
        cpu_if.ADR = 12'h041; cpu_if.SEL = '0;
        #1;
        chk("rf_miss_rty", 128'(cpu_if.RTY), 128'(1));
        chk("rf_miss_memidle", 128'(mem_if.CYC), 128'(0));
        @(negedge clk);
        #1;
        chk("rf_fill_cyc", 128'(mem_if.CYC), 128'(1));
        chk("rf_fill_we", 128'(mem_if.WE), 128'(0));
        chk("rf_fill_adr", 128'(mem_if.ADR), 128'(12'h041));
        rst = 1'b1;
        #1;
        chk("rf_drop_cyc", 128'(mem_if.CYC), 128'(0));
        chk("rf_drop_stb", 128'(mem_if.STB), 128'(0));
        chk("rf_drop_ack", 128'(cpu_if.ACK), 128'(0));
        chk("rf_drop_rty", 128'(cpu_if.RTY), 128'(1));
        @(negedge clk);
        rst = 1'b0;
        cpu_if.CYC = 1'b0; cpu_if.STB = 1'b0;
        v = mk(0, 12'h041, 16'h0000, '0, 1, f_mem(12'h041), 2, 0, 12'h0, '0, 1, 12'h041);
        run_vec(v, 20);
        v = mk(0, 12'h010, 16'h0000, '0, 1, {16{8'hA5}}, 2, 0, 12'h0, '0, 1, 12'h010);
        run_vec(v, 21);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
